// File: rtl/dspl_drv_mux.sv
// Multiplexed common-anode seven-segment driver with PWM brightness,
// per-digit blink, per-slot input snapshot and a one-cycle anode dead time.
module dspl_drv_mux #(
  parameter int NUM_DIGITS   = 8,
  parameter int SUB_COUNT    = 6250,
  parameter int BRIGHT_BITS  = 4,
  parameter int BLINK_FRAMES = 62
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_DIGITS*6-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  output logic [NUM_DIGITS-1:0]     an,
  output logic [7:0]                dec_ddp,
  output logic                      frame_start
);

  localparam int SW = (SUB_COUNT > 1) ? $clog2(SUB_COUNT) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int KW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  typedef struct packed {
    logic       en;
    logic [3:0] val;
    logic       dp;
  } dig_t;

  logic [SW-1:0]          sub_q, sub_d;
  logic [BRIGHT_BITS-1:0] phase_q, phase_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [KW-1:0]          bcnt_q, bcnt_d;
  logic                   bph_q, bph_d;
  dig_t                   snap_q, snap_d;
  logic                   blank_q, blank_d;
  logic [BRIGHT_BITS-1:0] bright_q, bright_d;
  logic [NUM_DIGITS-1:0]  an_q, an_d;
  logic [7:0]             dec_q, dec_d;
  logic                   fs_q, fs_d;

  dig_t cur;
  logic cur_blink;
  logic slot_start;
  logic lit;
  logic sub_wrap;
  logic ph_wrap;
  logic idx_wrap;
  logic bcnt_wrap;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    seg7 = 7'b1111111;
    case (v)
      4'h0: seg7 = 7'b0000001;
      4'h1: seg7 = 7'b1001111;
      4'h2: seg7 = 7'b0010010;
      4'h3: seg7 = 7'b0000110;
      4'h4: seg7 = 7'b1001100;
      4'h5: seg7 = 7'b0100100;
      4'h6: seg7 = 7'b0100000;
      4'h7: seg7 = 7'b0001111;
      4'h8: seg7 = 7'b0000000;
      4'h9: seg7 = 7'b0000100;
      4'hA: seg7 = 7'b0001000;
      4'hB: seg7 = 7'b1100000;
      4'hC: seg7 = 7'b0110001;
      4'hD: seg7 = 7'b1000010;
      4'hE: seg7 = 7'b0110000;
      4'hF: seg7 = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    cur       = '0;
    cur_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        cur       = digits_in[6*k +: 6];
        cur_blink = blink_en[k];
      end
    end
  end

  assign sub_wrap   = (sub_q == SW'(SUB_COUNT - 1));
  assign ph_wrap    = sub_wrap && (phase_q == '1);
  assign idx_wrap   = ph_wrap && (idx_q == IW'(NUM_DIGITS - 1));
  assign bcnt_wrap  = idx_wrap && (bcnt_q == KW'(BLINK_FRAMES - 1));
  assign slot_start = (sub_q == '0) && (phase_q == '0);
  assign lit = snap_q.en & ~blank_q & (phase_q <= bright_q);

  always_comb begin
    sub_d    = sub_q;
    phase_d  = phase_q;
    idx_d    = idx_q;
    bcnt_d   = bcnt_q;
    bph_d    = bph_q;
    snap_d   = snap_q;
    blank_d  = blank_q;
    bright_d = bright_q;
    dec_d    = dec_q;
    an_d     = '1;
    fs_d     = 1'b0;

    // Slot start latches everything the slot shows and blanks anodes.
    if (slot_start) begin
      snap_d  = cur;
      blank_d = cur_blink & bph_q;
      dec_d   = {seg7(cur.val), cur.dp};
      fs_d    = (idx_q == '0);
      if (idx_q == '0) begin
        bright_d = brightness;
      end
    end else begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_q == IW'(k)) begin
          an_d[k] = ~lit;
        end
      end
    end

    sub_d = sub_wrap ? '0 : sub_q + SW'(1);
    if (sub_wrap) begin
      phase_d = phase_q + BRIGHT_BITS'(1);
    end
    if (ph_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IW'(1);
    end
    if (idx_wrap) begin
      bcnt_d = bcnt_wrap ? '0 : bcnt_q + KW'(1);
    end
    if (bcnt_wrap) begin
      bph_d = ~bph_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sub_q    <= '0;
      phase_q  <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      bph_q    <= 1'b0;
      snap_q   <= '0;
      blank_q  <= 1'b0;
      bright_q <= '0;
      an_q     <= '1;
      dec_q    <= 8'hFF;
      fs_q     <= 1'b0;
    end else begin
      sub_q    <= sub_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      bph_q    <= bph_d;
      snap_q   <= snap_d;
      blank_q  <= blank_d;
      bright_q <= bright_d;
      an_q     <= an_d;
      dec_q    <= dec_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign dec_ddp     = dec_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_dspl_drv_mux.sv
// Directed bench for dspl_drv_mux at 4 digits, 8-clock slots,
// 32-clock frames and a 2-frame blink period.
module tb_dspl_drv_mux;

  logic        clock;
  logic        reset;
  logic [23:0] digits_in;
  logic [3:0]  blink_en;
  logic [1:0]  brightness;
  logic [3:0]  an;
  logic [7:0]  dec_ddp;
  logic        frame_start;

  int vectors = 0;
  int errors  = 0;

  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic [7:0] exp_dec [4];

  dspl_drv_mux #(
    .NUM_DIGITS   (4),
    .SUB_COUNT    (2),
    .BRIGHT_BITS  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digits_in   (digits_in),
    .blink_en    (blink_en),
    .brightness  (brightness),
    .an          (an),
    .dec_ddp     (dec_ddp),
    .frame_start (frame_start)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] dg(input logic en,
                                    input logic [3:0] v,
                                    input logic dp);
    return {en, v, dp};
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Checks cycles c0..c0+n-1 of the current frame; vis marks lit digits.
  task automatic run_cycles(input int c0, input int n,
                            input int b, input logic [3:0] vis);
    int k;
    int s;
    logic [3:0] exp_an;
    for (int c = c0; c < c0 + n; c++) begin
      step();
      k = c / 8;
      s = c % 8;
      exp_an = 4'hF;
      if (s != 0 && (s / 2) <= b && vis[k]) exp_an[k] = 1'b0;
      chk($sformatf("an c%0d", c), {4'h0, an}, {4'h0, exp_an});
      chk($sformatf("dec c%0d", c), dec_ddp, exp_dec[k]);
      chk($sformatf("fs c%0d", c), {7'h0, frame_start}, 8'(c == 0));
    end
  endtask

  initial begin
    reset      = 1'b0;
    blink_en   = 4'b0000;
    brightness = 2'd3;
    digits_in  = {dg(1'b1, 4'h4, 1'b1), dg(1'b1, 4'h3, 1'b1),
                  dg(1'b1, 4'h2, 1'b1), dg(1'b1, 4'h1, 1'b1)};
    for (int k = 0; k < 4; k++) exp_dec[k] = {SEG[k+1], 1'b1};

    step();
    step();
    chk("rst an", {4'h0, an}, 8'h0F);
    chk("rst dec", dec_ddp, 8'hFF);
    chk("rst fs", {7'h0, frame_start}, 8'h00);
    reset = 1'b1;

    // Full brightness, then dimmest.
    run_cycles(0, 32, 3, 4'b1111);
    brightness = 2'd0;
    run_cycles(0, 32, 0, 4'b1111);
    // Mid-frame brightness change waits for the next frame.
    run_cycles(0, 11, 0, 4'b1111);
    brightness = 2'd2;
    run_cycles(11, 21, 0, 4'b1111);
    run_cycles(0, 32, 2, 4'b1111);

    // Disabled digit 2 with its decimal point on.
    digits_in[17:12] = dg(1'b0, 4'h3, 1'b0);
    exp_dec[2] = {SEG[3], 1'b0};
    run_cycles(0, 32, 2, 4'b1011);
    digits_in[17:12] = dg(1'b1, 4'h3, 1'b1);
    exp_dec[2] = {SEG[3], 1'b1};

    // Asynchronous reset in slot 2, clock 4.
    run_cycles(0, 21, 2, 4'b1111);
    reset = 1'b0;
    #1;
    chk("arst an", {4'h0, an}, 8'h0F);
    chk("arst dec", dec_ddp, 8'hFF);
    chk("arst fs", {7'h0, frame_start}, 8'h00);
    step();
    chk("arst hold an", {4'h0, an}, 8'h0F);
    chk("arst hold dec", dec_ddp, 8'hFF);
    brightness = 2'd3;
    blink_en   = 4'b0010;
    reset      = 1'b1;

    // Blink digit 1: lit, lit, dark, dark, lit, lit.
    run_cycles(0, 32, 3, 4'b1111);
    run_cycles(0, 32, 3, 4'b1111);
    run_cycles(0, 32, 3, 4'b1101);
    run_cycles(0, 32, 3, 4'b1101);
    run_cycles(0, 32, 3, 4'b1111);
    // Digit 3 changes at slot 3 clock 3; visible next frame only.
    run_cycles(0, 28, 3, 4'b1111);
    digits_in[23:18] = dg(1'b1, 4'hF, 1'b1);
    run_cycles(28, 4, 3, 4'b1111);
    exp_dec[3] = {SEG[15], 1'b1};
    run_cycles(0, 32, 3, 4'b1101);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/dspl_drv_mux.md
Name: dspl_drv_mux

Overview:
- Parametrised successor to the team's 8-digit multiplexed seven-segment driver.
- Drives NUM_DIGITS common-anode digits from a single clock domain, using tick enables instead of a derived clock.
- Adds global PWM brightness, per-digit blink, per-slot input snapshot (no tearing) and one-cycle anti-ghost dead time.
- Sits between the display data sources (clock/time formatting logic) and the board anode/segment pins.

Parameters:
- NUM_DIGITS, 8, number of multiplexed digits (1..16).
- SUB_COUNT, 6250, clocks per PWM subphase (>=2). Slot = SUB_COUNT*2^BRIGHT_BITS clocks; defaults give 1 ms at 100 MHz.
- BRIGHT_BITS, 4, brightness width; slot is split into 2^BRIGHT_BITS subphases.
- BLINK_FRAMES, 62, full frames per blink-phase toggle (~0.5 s at defaults).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- digits_in  in  NUM_DIGITS*6  digit k occupies bits [6k+5:6k]: [6k] decimal point (active-low), [6k+4:6k+1] hex value, [6k+5] enable (active-high). Digit 0 = leftmost.
- blink_en  in  NUM_DIGITS  per-digit blink request.
- brightness  in  BRIGHT_BITS  global brightness; 0 = dimmest nonzero, all-ones = full.
- an  out  NUM_DIGITS  active-low anodes; an[k] drives digit k.
- dec_ddp  out  8  active-low segments: [7:1] = a..g, [0] = dp.
- frame_start  out  1  one-cycle pulse at the start of digit 0's slot.

Behaviour:
- Counters:
  - sub_cnt 0..SUB_COUNT-1 increments every clock.
  - On sub_cnt wrap, phase 0..2^BRIGHT_BITS-1 increments.
  - On phase wrap, idx 0..NUM_DIGITS-1 increments and wraps to 0.
  - On idx wrap (end of frame), blink_cnt 0..BLINK_FRAMES-1 increments. On its wrap, blink_phase toggles.
- Slot-start edge (sub_cnt==0, phase==0, idx==k):
  - snapshot <= digits_in[6k+5:6k]; blank_k <= blink_en[k] & blink_phase.
  - dec_ddp <= decode(digits_in[6k+4:6k+1]) with dp bit = digits_in[6k].
  - an <= all ones (dead time).
  - frame_start <= (k==0).
  - If k==0, bright_q <= brightness.
- Every other edge in the slot:
  - an[k] <= ~(snapshot.enable & ~blank_k & (phase <= bright_q)); all other an bits <= 1.
  - dec_ddp holds; frame_start <= 0.
- Exactly one or zero an bits are low at any time. Outputs are registered: 1-clock latency from counter state.
- Decoder (active-low a..g), values 0..F:
  - 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111
  - 0000000, 0000100, 0001000, 1100000, 0110001, 1000010, 0110000, 0111000
- Input timing:
  - digits_in and blink_en changes mid-slot take effect at that digit's next slot.
  - brightness changes take effect at the next frame start.
- Lit cycles per slot = (bright_q+1)*SUB_COUNT - 1 (dead cycle removed). brightness=max gives slot-1 lit cycles.
- Reset (reset==0, asynchronous, any time):
  - an = all ones, dec_ddp = 8'hFF, frame_start = 0.
  - All counters, snapshot, bright_q, blink_phase = 0.
  - After release, the first edge is the slot-start edge of digit 0.
- Width rules:
  - Counter widths are $clog2 of their ranges (minimum 1).
  - phase <= bright_q is an unsigned compare at BRIGHT_BITS width.
  - idx indexes digits_in by a 6*idx part-select.

Test Plan (NUM_DIGITS=4, SUB_COUNT=2, BRIGHT_BITS=2, BLINK_FRAMES=2 → slot 8 clk, frame 32 clk):
- Reset release, all digits enabled, values 1,2,3,4, brightness=3 → frame_start pulses every 32 clk. In each slot an = 1111 for 1 clk, then an[k]=0 for 7 clk. dec_ddp = 1001111x, 0010010x, 0000110x, 1001100x in sequence.
- brightness=0 → an[k] low exactly 1 clk per slot. Change brightness to 2 mid-frame → no effect until the next frame_start, then 5 clk low per slot.
- Digit 2 enable=0, dp bit=0 → an stays 1111 during slot 2; dec_ddp[0]=0 during slot 2.
- blink_en=0010, brightness=3 → digit 1 lit in frames 0-1, dark in frames 2-3, lit again in frames 4-5. Other digits are unaffected.
- Change digits_in digit 3 from 4 to F at slot-3 clk 3 → dec_ddp stays 1001100x for the rest of the slot, becomes 0111000x next frame.
- Assert reset at slot-2 clk 4 → an=1111 and dec_ddp=FF immediately (async). After release, digit 0 slot restarts with frame_start=1.
